// File: rtl/gate_response_checker.sv
// Sweeps the four input vectors of a 2-input gate, samples its output after a settle delay,
// and counts functional mismatches and X/Z outputs against the FUNC truth table.
module gate_response_checker #(
    parameter logic [3:0]  FUNC   = 4'b1000,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned SWEEPS = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             in1_o,
    output logic             in2_o,
    input  logic             dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] xz_cnt_o,
    output logic [1:0]       last_fail_o
);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

    localparam logic [3:0]       SettleLoad = 4'(SETTLE - 1);
    localparam logic [7:0]       LastSweep  = 8'(SWEEPS - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       sweep_q, sweep_d;
    logic [3:0]       settle_q, settle_d;
    logic [1:0]       in_q, in_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] xz_q, xz_d;
    logic [1:0]       last_q, last_d;
    logic             pass_q, pass_d;

    // Case-inequality so that X and Z are both caught; a 2-state view never flags.
    logic out_xz;
    logic mismatch;
    assign out_xz   = (dut_out_i !== 1'b0) && (dut_out_i !== 1'b1);
    assign mismatch = (dut_out_i != FUNC[vec_q]);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        sweep_d  = sweep_q;
        settle_d = settle_q;
        in_d     = in_q;
        err_d    = err_q;
        xz_d     = xz_q;
        last_d   = last_q;
        pass_d   = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StDrive;
                    err_d   = '0;
                    xz_d    = '0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    sweep_d = 8'd0;
                end
            end
            StDrive: begin
                in_d     = vec_q;
                settle_d = SettleLoad;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StSample: begin
                if (out_xz) begin
                    if (xz_q != '1) xz_d = xz_q + CntOne;
                    last_d = vec_q;
                end else if (mismatch) begin
                    if (err_q != '1) err_d = err_q + CntOne;
                    last_d = vec_q;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = StDrive;
                end else if (sweep_q != LastSweep) begin
                    vec_d   = 2'd0;
                    sweep_d = sweep_q + 8'd1;
                    state_d = StDrive;
                end else begin
                    // Uses this cycle's updated counts so pass is valid alongside done.
                    pass_d  = (err_d == '0) && (xz_d == '0);
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            vec_q    <= 2'd0;
            sweep_q  <= 8'd0;
            settle_q <= 4'd0;
            in_q     <= 2'd0;
            err_q    <= '0;
            xz_q     <= '0;
            last_q   <= 2'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            sweep_q  <= sweep_d;
            settle_q <= settle_d;
            in_q     <= in_d;
            err_q    <= err_d;
            xz_q     <= xz_d;
            last_q   <= last_d;
            pass_q   <= pass_d;
        end
    end

    assign in1_o       = in_q[0];
    assign in2_o       = in_q[1];
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
    assign xz_cnt_o    = xz_q;
    assign last_fail_o = last_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Table-driven bench for gate_response_checker: three instances (default, SWEEPS=3,
// CNT_W=2/SWEEPS=4) each driven by a behavioural gate model selected per run.
module tb_gate_response_checker;

    localparam logic [3:0] FUNC = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s[3];
    logic       in1_s[3];
    logic       in2_s[3];
    logic       dut_s[3];
    logic       busy_s[3];
    logic       done_s[3];
    logic       pass_s[3];
    logic [7:0] err_s[3];
    logic [7:0] xz_s[3];
    logic [1:0] last_s[3];
    logic [1:0] err2;
    logic [1:0] xz2;
    int         mode_s[3];
    int         checks = 0;
    int         failures = 0;
    logic       four_state;

    always #5 clk = ~clk;

    // Gate models: 0 AND, 1 OR, 2 Z, 3 XOR, 4 const0, 5 NAND, 6 const1, 7 X
    function automatic logic gate(input int mode, input logic [1:0] v);
        case (mode)
            0:       return v[1] & v[0];
            1:       return v[1] | v[0];
            2:       return 1'bz;
            3:       return v[1] ^ v[0];
            4:       return 1'b0;
            5:       return ~(v[1] & v[0]);
            6:       return 1'b1;
            default: return 1'bx;
        endcase
    endfunction

    assign dut_s[0] = gate(mode_s[0], {in2_s[0], in1_s[0]});
    assign dut_s[1] = gate(mode_s[1], {in2_s[1], in1_s[1]});
    assign dut_s[2] = gate(mode_s[2], {in2_s[2], in1_s[2]});
    assign err_s[2] = {6'd0, err2};
    assign xz_s[2]  = {6'd0, xz2};

    gate_response_checker u_def (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .in1_o(in1_s[0]), .in2_o(in2_s[0]),
        .dut_out_i(dut_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]),
        .err_cnt_o(err_s[0]), .xz_cnt_o(xz_s[0]), .last_fail_o(last_s[0])
    );

    gate_response_checker #(.SWEEPS(3)) u_s3 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .in1_o(in1_s[1]), .in2_o(in2_s[1]),
        .dut_out_i(dut_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]),
        .err_cnt_o(err_s[1]), .xz_cnt_o(xz_s[1]), .last_fail_o(last_s[1])
    );

    gate_response_checker #(.CNT_W(2), .SWEEPS(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .in1_o(in1_s[2]), .in2_o(in2_s[2]),
        .dut_out_i(dut_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]), .pass_o(pass_s[2]),
        .err_cnt_o(err2), .xz_cnt_o(xz2), .last_fail_o(last_s[2])
    );

    typedef struct {
        int  inst;
        int  mode;
        bit  is_xz;
        int  exp_err;
        int  exp_xz;
        int  exp_last;
        int  exp_pass;
        int  exp_len;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected counts for a gate model as this simulator represents its values.
    task automatic exp_model(input int mode, input int sweeps, input int cntw,
                             output int e, output int x, output int l);
        int max;
        logic val;
        max = (1 << cntw) - 1;
        e = 0;
        x = 0;
        l = 0;
        for (int s = 0; s < sweeps; s++) begin
            for (int v = 0; v < 4; v++) begin
                val = gate(mode, 2'(v));
                if ($isunknown(val)) begin
                    if (x < max) x++;
                    l = v;
                end else if (val != FUNC[v]) begin
                    if (e < max) e++;
                    l = v;
                end
            end
        end
    endtask

    // Start cycle is n=0; returns n of the cycle in which done is seen.
    task automatic do_run(input int k, output int n);
        start_s[k] = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        start_s[k] = 1'b0;
        n = 1;
        check("busy_after_start", int'(busy_s[k]), 1);
        while (!done_s[k] && n < 400) begin
            if (k == 0 && n >= 4 && n <= 16 && n % 4 == 0)
                check("vector_driven", int'({in2_s[k], in1_s[k]}), n / 4 - 1);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    vec_t tbl[8];
    int   sweeps_of[3] = '{1, 3, 4};
    int   cntw_of[3]   = '{8, 8, 2};

    initial begin
        int n, e, x, l, ndone, first;
        tbl[0] = '{0, 0, 1'b0, 0, 0, 0, 1, 17};
        tbl[1] = '{0, 1, 1'b0, 2, 0, 2, 0, 17};
        tbl[2] = '{0, 2, 1'b1, 0, 4, 3, 0, 17};
        tbl[3] = '{0, 3, 1'b0, 3, 0, 3, 0, 17};
        tbl[4] = '{0, 6, 1'b0, 3, 0, 2, 0, 17};
        tbl[5] = '{1, 4, 1'b0, 3, 0, 3, 0, 49};
        tbl[6] = '{2, 5, 1'b0, 3, 0, 3, 0, 65};
        tbl[7] = '{2, 7, 1'b1, 0, 3, 3, 0, 65};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            mode_s[k]  = 0;
        end
        four_state = $isunknown(gate(2, 2'd0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_in1", int'(in1_s[0]), 0);
        check("rst_in2", int'(in2_s[0]), 0);
        check("rst_busy", int'(busy_s[0]), 0);
        check("rst_done", int'(done_s[0]), 0);
        check("rst_pass", int'(pass_s[0]), 0);
        check("rst_err", int'(err_s[0]), 0);
        check("rst_xz", int'(xz_s[0]), 0);
        check("rst_last", int'(last_s[0]), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e = tbl[i].exp_err;
            x = tbl[i].exp_xz;
            l = tbl[i].exp_last;
            if (tbl[i].is_xz && !four_state)
                exp_model(tbl[i].mode, sweeps_of[tbl[i].inst], cntw_of[tbl[i].inst], e, x, l);
            mode_s[tbl[i].inst] = tbl[i].mode;
            do_run(tbl[i].inst, n);
            check($sformatf("row%0d_len", i), n, tbl[i].exp_len);
            check($sformatf("row%0d_err", i), int'(err_s[tbl[i].inst]), e);
            check($sformatf("row%0d_xz", i), int'(xz_s[tbl[i].inst]), x);
            check($sformatf("row%0d_last", i), int'(last_s[tbl[i].inst]), l);
            check($sformatf("row%0d_pass", i), int'(pass_s[tbl[i].inst]),
                  (e == 0 && x == 0) ? 1 : 0);
            @(posedge clk);
            #1;
            check($sformatf("row%0d_done_pulse", i), int'(done_s[tbl[i].inst]), 0);
            check($sformatf("row%0d_idle", i), int'(busy_s[tbl[i].inst]), 0);
        end

        // Reset in the middle of vector 2's settle time, OR model so err is already 1.
        mode_s[0]  = 1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_err_before_rst", int'(err_s[0]), 1);
        check("mid_in_before_rst", int'({in2_s[0], in1_s[0]}), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in", int'({in2_s[0], in1_s[0]}), 0);
        check("mid_rst_busy", int'(busy_s[0]), 0);
        check("mid_rst_done", int'(done_s[0]), 0);
        check("mid_rst_err", int'(err_s[0]), 0);
        check("mid_rst_last", int'(last_s[0]), 0);

        // Start held for three cycles: only the first is accepted.
        start_s[0] = 1'b1;
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) start_s[0] = 1'b0;
            if (done_s[0]) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        check("held_start_done_count", ndone, 1);
        check("held_start_done_cycle", first, 17);
        check("held_start_err", int'(err_s[0]), 2);
        check("held_start_last", int'(last_s[0]), 2);

        // Start coinciding with reset is discarded.
        rst = 1'b1;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_s[0] = 1'b0;
        check("rst_start_busy0", int'(busy_s[0]), 0);
        @(posedge clk);
        #1;
        check("rst_start_busy1", int'(busy_s[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
